// File: rtl/fir_stereo_sched.sv
// fir_stereo_sched: time-shares one FIR MAC engine between the left and right
// channels, one pending sample per channel, results routed back per channel.
module fir_stereo_sched #(
  parameter int DW      = 24,
  parameter int TIMEOUT = 511,
  parameter int TW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] l_din,
  input  logic          l_valid,
  input  logic [DW-1:0] r_din,
  input  logic          r_valid,
  output logic [DW-1:0] eng_din,
  output logic          eng_din_valid,
  output logic          eng_chan,
  input  logic [DW-1:0] eng_dout,
  input  logic          eng_dout_valid,
  output logic [DW-1:0] l_dout,
  output logic          l_dout_valid,
  output logic [DW-1:0] r_dout,
  output logic          r_dout_valid,
  output logic          busy,
  output logic          ovr_l,
  output logic          ovr_r,
  output logic          tmo_err,
  input  logic          clr_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [DW-1:0] pend_l, pend_r;
  logic          pend_lv, pend_rv;
  logic          last_l;
  logic          pick;
  logic [TW-1:0] cnt;
  logic          done, tmo;
  logic          take_l, take_r;
  logic          start, hold;

  assign done   = (state == WAIT) && eng_dout_valid;
  assign tmo    = (state == WAIT) && !eng_dout_valid && (cnt == TMAX);
  assign take_l = (state == ISSUE) && !eng_chan;
  assign take_r = (state == ISSUE) && eng_chan;
  assign start  = (state == IDLE) && (state_n == ISSUE);
  // No arbitration during a result pulse: spaces jobs at latency + 3.
  assign hold   = l_dout_valid || r_dout_valid;

  always_comb begin
    state_n = state;
    pick    = pend_rv;
    if (pend_lv && pend_rv) pick = last_l;
    unique case (state)
      IDLE:
        if (!hold && (pend_lv || pend_rv)) state_n = ISSUE;
      ISSUE:
        state_n = WAIT;
      WAIT:
        if (done || tmo) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pend_l        <= '0;
      pend_r        <= '0;
      pend_lv       <= 1'b0;
      pend_rv       <= 1'b0;
      last_l        <= 1'b0;
      cnt           <= '0;
      eng_din       <= '0;
      eng_din_valid <= 1'b0;
      eng_chan      <= 1'b0;
      l_dout        <= '0;
      l_dout_valid  <= 1'b0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      busy          <= 1'b0;
      ovr_l         <= 1'b0;
      ovr_r         <= 1'b0;
      tmo_err       <= 1'b0;
    end else begin
      state         <= state_n;
      busy          <= (state_n != IDLE);
      eng_din_valid <= start;
      if (start) begin
        eng_chan <= pick;
        eng_din  <= pick ? pend_r : pend_l;
      end
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;

      if (l_valid) pend_l <= l_din;
      if (r_valid) pend_r <= r_din;
      if (l_valid)     pend_lv <= 1'b1;
      else if (take_l) pend_lv <= 1'b0;
      if (r_valid)     pend_rv <= 1'b1;
      else if (take_r) pend_rv <= 1'b0;

      if (l_valid && pend_lv && !take_l) ovr_l <= 1'b1;
      else if (clr_err)                  ovr_l <= 1'b0;
      if (r_valid && pend_rv && !take_r) ovr_r <= 1'b1;
      else if (clr_err)                  ovr_r <= 1'b0;
      if (tmo)          tmo_err <= 1'b1;
      else if (clr_err) tmo_err <= 1'b0;

      l_dout_valid <= done && !eng_chan;
      r_dout_valid <= done && eng_chan;
      if (done && !eng_chan) l_dout <= eng_dout;
      if (done && eng_chan)  r_dout <= eng_dout;
      if (done) last_l <= !eng_chan;
    end
  end

endmodule

// File: tb/tb_fir_stereo_sched.sv
// tb_fir_stereo_sched: job-level reference model compared every cycle,
// engine stand-in with fixed latency, per-channel stream scoreboard.
module tb_fir_stereo_sched;

  localparam int DW  = 24;
  localparam int TO  = 511;
  localparam int LAT = 264;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] l_din = '0, r_din = '0;
  logic          l_valid = 1'b0, r_valid = 1'b0;
  logic [DW-1:0] eng_din;
  logic          eng_din_valid, eng_chan;
  logic [DW-1:0] eng_dout = '0;
  logic          eng_dout_valid = 1'b0;
  logic [DW-1:0] l_dout, r_dout;
  logic          l_dout_valid, r_dout_valid;
  logic          busy, ovr_l, ovr_r, tmo_err;
  logic          clr_err = 1'b0;

  int checks = 0;
  int fails  = 0;

  fir_stereo_sched #(.DW(DW), .TIMEOUT(TO), .TW(9)) dut (
    .clk(clk), .rst(rst),
    .l_din(l_din), .l_valid(l_valid),
    .r_din(r_din), .r_valid(r_valid),
    .eng_din(eng_din), .eng_din_valid(eng_din_valid),
    .eng_chan(eng_chan),
    .eng_dout(eng_dout), .eng_dout_valid(eng_dout_valid),
    .l_dout(l_dout), .l_dout_valid(l_dout_valid),
    .r_dout(r_dout), .r_dout_valid(r_dout_valid),
    .busy(busy), .ovr_l(ovr_l), .ovr_r(ovr_r),
    .tmo_err(tmo_err), .clr_err(clr_err)
  );

  initial forever #5 clk = ~clk;

  // Engine stand-in: answers LAT cycles after an issue with din ^ xmask.
  bit            eng_en = 1'b1;
  logic [DW-1:0] xmask  = '0;
  logic [DW-1:0] held   = '0;
  int            cd     = 0;

  initial forever begin
    @(posedge clk);
    #1;
    eng_dout_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        eng_dout_valid = 1'b1;
        eng_dout = held ^ xmask;
      end
    end
    if (eng_din_valid && eng_en) begin
      cd = LAT;
      held = eng_din;
    end
  end

  // Reference model: a pending slot per channel and at most one job in
  // flight (0 none, 1 being issued, 2 waiting in the engine).
  bit            pv[2];
  logic [DW-1:0] pd[2];
  int            job, age;
  bit            ch, last_l;
  logic [DW-1:0] e_din, e_ld, e_rd;
  bit            e_dv, e_ch, e_lv, e_rv, e_busy, e_ovl, e_ovr, e_tmo;

  task automatic m_reset();
    pv = '{0, 0};
    pd = '{0, 0};
    job = 0; age = 0; ch = 0; last_l = 0;
    e_din = '0; e_ld = '0; e_rd = '0;
    e_dv = 0; e_ch = 0; e_lv = 0; e_rv = 0;
    e_busy = 0; e_ovl = 0; e_ovr = 0; e_tmo = 0;
  endtask

  task automatic m_step();
    bit            vin[2];
    logic [DW-1:0] din[2];
    bit            cons[2];
    bit            done, tmo, hold;
    vin[0] = l_valid; vin[1] = r_valid;
    din[0] = l_din;   din[1] = r_din;
    hold = e_lv || e_rv;
    done = (job == 2) && eng_dout_valid;
    tmo  = (job == 2) && !eng_dout_valid && (age == TO - 1);
    for (int x = 0; x < 2; x++) cons[x] = (job == 1) && (ch == x);
    e_lv = done && !ch;
    e_rv = done && ch;
    if (e_lv) e_ld = eng_dout;
    if (e_rv) e_rd = eng_dout;
    e_ovl = (vin[0] && pv[0] && !cons[0]) || (e_ovl && !clr_err);
    e_ovr = (vin[1] && pv[1] && !cons[1]) || (e_ovr && !clr_err);
    e_tmo = tmo || (e_tmo && !clr_err);
    e_dv = 0;
    if (job == 1) begin
      job = 2;
      age = 0;
    end else if (job == 2) begin
      if (done) begin
        job = 0;
        last_l = !ch;
      end else if (tmo) job = 0;
      else age++;
    end else if (!hold && (pv[0] || pv[1])) begin
      ch = (pv[0] && pv[1]) ? last_l : pv[1];
      job = 1;
      e_dv = 1;
      e_din = pd[ch];
      e_ch = ch;
    end
    e_busy = (job != 0);
    for (int x = 0; x < 2; x++) begin
      if (vin[x]) begin
        pv[x] = 1;
        pd[x] = din[x];
      end else if (cons[x]) pv[x] = 0;
    end
  endtask

  // Stream scoreboard state
  bit            sb_on = 0;
  logic [DW-1:0] lq[$], rq[$];
  int            lcnt = 0, rcnt = 0;
  logic [79:0]   act_v, exp_v;
  logic [DW-1:0] want;

  initial forever begin
    @(negedge clk);
    if (rst) m_reset();
    act_v = {eng_din, eng_din_valid, eng_chan, l_dout, l_dout_valid,
             r_dout, r_dout_valid, busy, ovr_l, ovr_r, tmo_err};
    exp_v = {e_din, e_dv, e_ch, e_ld, e_lv, e_rd, e_rv,
             e_busy, e_ovl, e_ovr, e_tmo};
    checks++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL model t=%0t got=%h exp=%h", $time, act_v, exp_v);
    end
    if (sb_on) begin
      if (l_valid) lq.push_back(l_din);
      if (r_valid) rq.push_back(r_din);
      if (l_dout_valid) begin
        checks++;
        lcnt++;
        want = (lq.size() > 0) ? lq.pop_front() ^ xmask : 'x;
        if (l_dout !== want) begin
          fails++;
          $display("FAIL sb_left got=%h exp=%h", l_dout, want);
        end
      end
      if (r_dout_valid) begin
        checks++;
        rcnt++;
        want = (rq.size() > 0) ? rq.pop_front() ^ xmask : 'x;
        if (r_dout !== want) begin
          fails++;
          $display("FAIL sb_right got=%h exp=%h", r_dout, want);
        end
      end
    end
    if (!rst) m_step();
  end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic adv(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    l_valid = 0; r_valid = 0; clr_err = 0;
    adv(3);
    chk("reset_state", 32'({eng_din, eng_din_valid, eng_chan, l_dout,
        l_dout_valid, r_dout, r_dout_valid, busy, ovr_l, ovr_r,
        tmo_err} != 0), 0);
    rst = 1'b0;
  endtask

  initial begin
    // 1: single left sample
    do_reset();
    adv(1); l_din = 24'h100000; l_valid = 1;
    adv(1); l_valid = 0;
    adv(1);
    chk("t1_issue_v", 32'(eng_din_valid), 1);
    chk("t1_issue_ch", 32'(eng_chan), 0);
    chk("t1_issue_d", 32'(eng_din), 32'h100000);
    chk("t1_busy", 32'(busy), 1);
    adv(265);
    chk("t1_lout_v", 32'(l_dout_valid), 1);
    chk("t1_lout_d", 32'(l_dout), 32'h100000);
    chk("t1_rout_v", 32'(r_dout_valid), 0);

    // 2: simultaneous left and right
    do_reset();
    adv(1);
    l_din = 24'h000001; l_valid = 1;
    r_din = 24'h7FFFFF; r_valid = 1;
    adv(1); l_valid = 0; r_valid = 0;
    adv(1);
    chk("t2_first_ch", 32'(eng_chan), 0);
    chk("t2_first_d", 32'(eng_din), 32'h000001);
    adv(265);
    chk("t2_lout_v", 32'(l_dout_valid), 1);
    chk("t2_lout_d", 32'(l_dout), 32'h000001);
    adv(2);
    chk("t2_second_v", 32'(eng_din_valid), 1);
    chk("t2_second_ch", 32'(eng_chan), 1);
    chk("t2_second_d", 32'(eng_din), 32'h7FFFFF);
    adv(265);
    chk("t2_rout_v", 32'(r_dout_valid), 1);
    chk("t2_rout_d", 32'(r_dout), 32'h7FFFFF);
    chk("t2_lout_hold", 32'(l_dout), 32'h000001);

    // 3: left overrun while right is in the engine
    do_reset();
    adv(1); r_din = 24'h0000AA; r_valid = 1;
    adv(1); r_valid = 0;
    adv(9); l_din = 24'h111111; l_valid = 1;
    adv(1); l_valid = 0;
    adv(9); l_din = 24'h222222; l_valid = 1;
    adv(1); l_valid = 0;
    adv(9); l_din = 24'h333333; l_valid = 1;
    adv(1); l_valid = 0;
    adv(9);
    chk("t3_ovr_l", 32'(ovr_l), 1);
    chk("t3_ovr_r", 32'(ovr_r), 0);
    adv(227);
    chk("t3_rout_d", 32'(r_dout), 32'h0000AA);
    adv(2);
    chk("t3_issue_v", 32'(eng_din_valid), 1);
    chk("t3_issue_d", 32'(eng_din), 32'h333333);
    adv(1); clr_err = 1;
    adv(1); clr_err = 0;
    chk("t3_clr", 32'(ovr_l), 0);
    adv(263);
    chk("t3_lout_v", 32'(l_dout_valid), 1);
    chk("t3_lout_d", 32'(l_dout), 32'h333333);

    // 4: silent engine, timeout, late result, recovery
    do_reset();
    eng_en = 0;
    adv(1); l_din = 24'h0F0F0F; l_valid = 1;
    adv(1); l_valid = 0;
    adv(1);
    chk("t4_issue_v", 32'(eng_din_valid), 1);
    adv(511);
    chk("t4_tmo_before", 32'(tmo_err), 0);
    chk("t4_busy_before", 32'(busy), 1);
    adv(1);
    chk("t4_tmo", 32'(tmo_err), 1);
    chk("t4_busy", 32'(busy), 0);
    adv(5);
    #1;
    eng_dout = 24'h777777;
    eng_dout_valid = 1;
    adv(1);
    chk("t4_late_l", 32'(l_dout_valid), 0);
    chk("t4_late_r", 32'(r_dout_valid), 0);
    eng_en = 1;
    adv(1); r_din = 24'h123456; r_valid = 1;
    adv(1); r_valid = 0;
    adv(1);
    chk("t4_next_ch", 32'(eng_chan), 1);
    adv(265);
    chk("t4_next_v", 32'(r_dout_valid), 1);
    chk("t4_next_d", 32'(r_dout), 32'h123456);
    chk("t4_sticky", 32'(tmo_err), 1);

    // 5: reset in the middle of a job
    do_reset();
    adv(1); l_din = 24'h0ABCDE; l_valid = 1;
    adv(1); l_valid = 0;
    adv(101);
    chk("t5_busy", 32'(busy), 1);
    rst = 1;
    #1;
    chk("t5_async", 32'({eng_din, eng_din_valid, eng_chan, busy} != 0), 0);
    adv(2); rst = 0;
    adv(163);
    chk("t5_ignored_v", 32'(l_dout_valid), 0);
    chk("t5_ignored_d", 32'(l_dout), 0);

    // 6: alternating stream, compressed 600-cycle frame period
    do_reset();
    xmask = 24'($urandom);
    sb_on = 1;
    for (int f = 0; f < 64; f++) begin
      adv(1); l_din = 24'($urandom); l_valid = 1;
      adv(1); l_valid = 0;
      adv(299); r_din = 24'($urandom); r_valid = 1;
      adv(1); r_valid = 0;
      adv(298);
    end
    adv(10);
    chk("t6_lcnt", 32'(lcnt), 64);
    chk("t6_rcnt", 32'(rcnt), 64);
    chk("t6_errs", 32'({ovr_l, ovr_r, tmo_err}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
